// File: rtl/dcache_if.sv
// dcache_if: datapath-side and memory-side signals of the data cache.
interface dcache_if;
  logic        halt, dmemREN, dmemWEN, datomic, dhit, flushed, dREN, dWEN, dwait;
  logic [31:0] dmemaddr, dmemstore, dmemload, daddr, dstore, dload;
  modport slave (
    input  halt, dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, dwait, dload,
    output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
  modport master (
    output halt, dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, dwait, dload,
    input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/dcache.sv
// dcache: direct-mapped write-back write-allocate data cache with LL/SC,
// halt-triggered flush and a final hit-minus-miss report write.
module dcache #(
  parameter int          SETS     = 16,
  parameter logic [31:0] CNT_ADDR = 32'h3100
) (
  input logic     CLK,
  input logic     nRST,
  dcache_if.slave bus
);
  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;
  typedef enum logic [2:0] {IDLE, WB, ALLOC, FLUSH, CNT, DONE} state_t;
  state_t          state, nstate;
  logic [SETS-1:0] valid, dirty;
  logic [TW-1:0]   tags [SETS];
  logic [31:0]     data [SETS];
  logic [31:0]     hits, misses, link_addr;
  logic            link_valid;
  logic [IW-1:0]   fidx, idx, cidx;
  logic [TW-1:0]   tg;
  logic            hit, sc, sc_ok, req, st_hit, ll_hit, clr_dirty, fill, fadv;
  assign idx   = bus.dmemaddr[IW+1:2];
  assign tg    = bus.dmemaddr[31:IW+2];
  assign hit   = valid[idx] && tags[idx] == tg;
  assign req   = bus.dmemREN | bus.dmemWEN;
  assign sc    = bus.dmemWEN & bus.datomic;
  assign sc_ok = link_valid && link_addr == bus.dmemaddr;
  assign cidx  = state == FLUSH ? fidx : idx;
  // Everything is gated by nRST so outputs read as idle while reset is held.
  always_comb begin
    nstate       = state;
    bus.dhit     = 1'b0;
    bus.dmemload = '0;
    bus.flushed  = 1'b0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    st_hit       = 1'b0;
    ll_hit       = 1'b0;
    clr_dirty    = 1'b0;
    fill         = 1'b0;
    fadv         = 1'b0;
    if (nRST) begin
      case (state)
        IDLE: begin
          if (bus.halt) nstate = FLUSH;
          else if (req) begin
            if (sc && !sc_ok) bus.dhit = 1'b1;
            else if (hit) begin
              bus.dhit     = 1'b1;
              bus.dmemload = sc ? 32'd1 : data[idx];
              st_hit       = bus.dmemWEN;
              ll_hit       = bus.dmemREN & ~bus.dmemWEN & bus.datomic;
            end else nstate = (valid[idx] && dirty[idx]) ? WB : ALLOC;
          end
        end
        WB: begin
          bus.dWEN   = 1'b1;
          bus.daddr  = {tags[idx], idx, 2'b00};
          bus.dstore = data[idx];
          clr_dirty  = ~bus.dwait;
          nstate     = bus.dwait ? WB : ALLOC;
        end
        ALLOC: begin
          bus.dREN  = 1'b1;
          bus.daddr = bus.dmemaddr;
          fill      = ~bus.dwait;
          nstate    = bus.dwait ? ALLOC : IDLE;
        end
        FLUSH: begin
          if (valid[fidx] && dirty[fidx]) begin
            bus.dWEN   = 1'b1;
            bus.daddr  = {tags[fidx], fidx, 2'b00};
            bus.dstore = data[fidx];
            fadv       = ~bus.dwait;
            clr_dirty  = ~bus.dwait;
          end else fadv = 1'b1;
          if (fadv && fidx == IW'(SETS - 1)) nstate = CNT;
        end
        CNT: begin
          bus.dWEN   = 1'b1;
          bus.daddr  = CNT_ADDR;
          bus.dstore = hits - misses;
          nstate     = bus.dwait ? CNT : DONE;
        end
        DONE:    bus.flushed = 1'b1;
        default: nstate = IDLE;
      endcase
    end
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      valid      <= '0;
      dirty      <= '0;
      hits       <= '0;
      misses     <= '0;
      link_valid <= 1'b0;
      link_addr  <= '0;
      fidx       <= '0;
    end else begin
      state <= nstate;
      if (bus.dhit) hits <= hits + 1'b1;
      if (nstate == ALLOC && state != ALLOC) misses <= misses + 1'b1;
      if (st_hit) dirty[idx] <= 1'b1;
      if (clr_dirty) dirty[cidx] <= 1'b0;
      if (fill) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end
      if (state != FLUSH) fidx <= '0;
      else if (fadv) fidx <= fidx + 1'b1;
      if (ll_hit) begin
        link_valid <= 1'b1;
        link_addr  <= bus.dmemaddr;
      end else if (bus.dhit && sc) link_valid <= 1'b0;
      else if (st_hit && bus.dmemaddr == link_addr) link_valid <= 1'b0;
    end
  end
  always_ff @(posedge CLK) begin
    if (st_hit) data[idx] <= bus.dmemstore;
    if (fill) begin
      data[idx] <= bus.dload;
      tags[idx] <= tg;
    end
  end
endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed checks of hit/miss, write-back, LL/SC, flush and reset.
module tb_dcache;
  logic CLK, nRST;
  int   checks, failures;
  dcache_if bus ();
  dcache #(.SETS(16), .CNT_ADDR(32'h3100)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    #2;
  endtask
  task automatic drive(input logic ren, input logic wen, input logic at,
                       input logic [31:0] a, input logic [31:0] d);
    bus.dmemREN   = ren;
    bus.dmemWEN   = wen;
    bus.datomic   = at;
    bus.dmemaddr  = a;
    bus.dmemstore = d;
    #1;
  endtask
  task automatic do_reset;
    nRST = 1'b0;
    bus.halt = 1'b0;
    bus.dwait = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick;
    tick;
    nRST = 1'b1;
  endtask
  logic [31:0] waddr [4];
  logic [31:0] wdata [4];
  int          nw, both;
  initial begin
    checks = 0;
    failures = 0;
    nRST = 1'b0;
    bus.halt = 1'b0;
    bus.dwait = 1'b0;
    bus.dload = 32'h0;
    drive(1'b0, 1'b1, 1'b1, 32'h40, 32'h5);
    chk("rst_dhit", 32'(bus.dhit), 32'd0);
    chk("rst_flushed", 32'(bus.flushed), 32'd0);
    chk("rst_dren", 32'(bus.dREN), 32'd0);
    chk("rst_dwen", 32'(bus.dWEN), 32'd0);
    chk("rst_daddr", bus.daddr, 32'h0);
    chk("rst_dstore", bus.dstore, 32'h0);
    chk("rst_dmemload", bus.dmemload, 32'h0);
    do_reset;
    // cold load 0x40
    bus.dload = 32'h1111_0040;
    drive(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    chk("cold_miss_dhit", 32'(bus.dhit), 32'd0);
    tick;
    chk("cold_alloc_dren", 32'(bus.dREN), 32'd1);
    chk("cold_alloc_dwen", 32'(bus.dWEN), 32'd0);
    chk("cold_alloc_daddr", bus.daddr, 32'h40);
    chk("cold_alloc_dhit", 32'(bus.dhit), 32'd0);
    tick;
    chk("cold_hit_dhit", 32'(bus.dhit), 32'd1);
    chk("cold_hit_data", bus.dmemload, 32'h1111_0040);
    chk("cold_hit_dren", 32'(bus.dREN), 32'd0);
    tick;
    // dirty victim write-back with a wait state
    do_reset;
    bus.dload = 32'h2222;
    drive(1'b0, 1'b1, 1'b0, 32'h80, 32'hAAAA);
    tick;
    chk("st_alloc_daddr", bus.daddr, 32'h80);
    tick;
    chk("st_hit_dhit", 32'(bus.dhit), 32'd1);
    tick;
    bus.dwait = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'hC0, 32'h0);
    chk("wb_miss_dhit", 32'(bus.dhit), 32'd0);
    tick;
    chk("wb_dwen", 32'(bus.dWEN), 32'd1);
    chk("wb_dren", 32'(bus.dREN), 32'd0);
    chk("wb_daddr", bus.daddr, 32'h80);
    chk("wb_dstore", bus.dstore, 32'hAAAA);
    tick;
    chk("wb_wait_dwen", 32'(bus.dWEN), 32'd1);
    bus.dwait = 1'b0;
    tick;
    chk("wb_alloc_dren", 32'(bus.dREN), 32'd1);
    chk("wb_alloc_daddr", bus.daddr, 32'hC0);
    bus.dload = 32'h3333;
    tick;
    chk("wb_after_hit", bus.dmemload, 32'h3333);
    tick;
    drive(1'b1, 1'b1, 1'b0, 32'hC0, 32'hBEEF);
    chk("renwen_dhit", 32'(bus.dhit), 32'd1);
    tick;
    drive(1'b1, 1'b0, 1'b0, 32'hC0, 32'h0);
    chk("renwen_stored", bus.dmemload, 32'hBEEF);
    tick;
    // LL then two SCs
    do_reset;
    bus.dload = 32'h7;
    drive(1'b1, 1'b0, 1'b1, 32'h100, 32'h0);
    tick;
    tick;
    chk("ll_hit_data", bus.dmemload, 32'h7);
    tick;
    drive(1'b0, 1'b1, 1'b1, 32'h100, 32'h5);
    chk("sc1_dhit", 32'(bus.dhit), 32'd1);
    chk("sc1_result", bus.dmemload, 32'd1);
    tick;
    drive(1'b0, 1'b1, 1'b1, 32'h100, 32'h6);
    chk("sc2_dhit", 32'(bus.dhit), 32'd1);
    chk("sc2_result", bus.dmemload, 32'd0);
    tick;
    drive(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
    chk("sc2_data_kept", bus.dmemload, 32'h5);
    tick;
    drive(1'b1, 1'b0, 1'b0, 32'h140, 32'h0);
    tick;
    chk("sc_dirty_wb_dwen", 32'(bus.dWEN), 32'd1);
    chk("sc_dirty_wb_daddr", bus.daddr, 32'h100);
    chk("sc_dirty_wb_dstore", bus.dstore, 32'h5);
    tick;
    tick;
    tick;
    // LL broken by a plain store
    do_reset;
    bus.dload = 32'h7;
    drive(1'b1, 1'b0, 1'b1, 32'h100, 32'h0);
    tick;
    tick;
    tick;
    drive(1'b0, 1'b1, 1'b0, 32'h100, 32'h9);
    chk("brk_store_dhit", 32'(bus.dhit), 32'd1);
    tick;
    drive(1'b0, 1'b1, 1'b1, 32'h100, 32'h77);
    chk("brk_sc_dhit", 32'(bus.dhit), 32'd1);
    chk("brk_sc_result", bus.dmemload, 32'd0);
    tick;
    drive(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
    chk("brk_sc_nowrite", bus.dmemload, 32'h9);
    tick;
    // 2 dirty frames, 4 hits, 2 misses, then halt
    do_reset;
    bus.dload = 32'h0;
    drive(1'b0, 1'b1, 1'b0, 32'h04, 32'h1234);
    tick;
    tick;
    tick;
    drive(1'b0, 1'b1, 1'b0, 32'h08, 32'h5678);
    tick;
    tick;
    tick;
    drive(1'b1, 1'b0, 1'b0, 32'h04, 32'h0);
    chk("fl_hit3", bus.dmemload, 32'h1234);
    tick;
    drive(1'b1, 1'b0, 1'b0, 32'h08, 32'h0);
    chk("fl_hit4", bus.dmemload, 32'h5678);
    tick;
    bus.halt = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h04, 32'h0);
    chk("halt_prio_dhit", 32'(bus.dhit), 32'd0);
    nw = 0;
    both = 0;
    for (int i = 0; i < 40 && !bus.flushed; i++) begin
      tick;
      if (bus.dREN && bus.dWEN) both++;
      if (bus.dWEN) begin
        if (nw < 4) begin
          waddr[nw] = bus.daddr;
          wdata[nw] = bus.dstore;
        end
        nw++;
      end
    end
    chk("fl_done", 32'(bus.flushed), 32'd1);
    chk("fl_nwrites", 32'(nw), 32'd3);
    chk("fl_no_both", 32'(both), 32'd0);
    chk("fl_w0_addr", waddr[0], 32'h04);
    chk("fl_w0_data", wdata[0], 32'h1234);
    chk("fl_w1_addr", waddr[1], 32'h08);
    chk("fl_w1_data", wdata[1], 32'h5678);
    chk("cnt_addr", waddr[2], 32'h3100);
    chk("cnt_value", wdata[2], 32'd2);
    tick;
    tick;
    tick;
    chk("done_held", 32'(bus.flushed), 32'd1);
    chk("done_dwen", 32'(bus.dWEN), 32'd0);
    chk("done_dhit", 32'(bus.dhit), 32'd0);
    // reset mid-ALLOC
    do_reset;
    bus.dwait = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
    tick;
    tick;
    chk("ma_alloc_dren", 32'(bus.dREN), 32'd1);
    nRST = 1'b0;
    #1;
    chk("ma_rst_dren", 32'(bus.dREN), 32'd0);
    chk("ma_rst_daddr", bus.daddr, 32'h0);
    nRST = 1'b1;
    bus.dwait = 1'b0;
    #1;
    chk("ma_remiss_dhit", 32'(bus.dhit), 32'd0);
    tick;
    chk("ma_realloc_dren", 32'(bus.dREN), 32'd1);
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
